// File: rtl/vdram_slot_arbiter.sv
// ============================================================================
// Module      : vdram_slot_arbiter
// Description : Grants each DRAM cycle to video, refresh or CPU, with video
//               holding fixed slots in a 16-cycle window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vdram_slot_arbiter #(
    parameter int REF_PERIOD = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cend,
    input  logic        go,
    input  logic [1:0]  bw,
    input  logic [20:0] video_addr,
    output logic        video_next,
    output logic        video_strobe,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    input  logic [15:0] cpu_wrdata,
    input  logic [1:0]  cpu_wrbsel,
    output logic        cpu_next,
    output logic        cpu_strobe,
    output logic        dram_req,
    output logic        dram_rnw,
    output logic        dram_refresh,
    output logic [20:0] dram_addr,
    output logic [15:0] dram_wrdata,
    output logic [1:0]  dram_bsel,
    input  logic        dram_rdstb,
    output logic        ref_overrun
);

    localparam int       c_REF_W    = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REF_PERIOD - 1);

    localparam logic [1:0] c_OWN_IDLE    = 2'd0;
    localparam logic [1:0] c_OWN_VIDEO   = 2'd1;
    localparam logic [1:0] c_OWN_CPU     = 2'd2;
    localparam logic [1:0] c_OWN_REFRESH = 2'd3;

    logic [1:0]         r_owner;
    logic [3:0]         r_wcnt;
    logic               r_go_d;
    logic [c_REF_W-1:0] r_refcnt;
    logic [1:0]         r_ref_pend;

    logic [3:0] w_slot;
    logic       w_vslot;
    logic [1:0] w_grant;
    logic       w_wrap;
    logic       w_ref_gnt;

    // A fresh go edge restarts the window so the first fetch lands immediately.
    assign w_slot = (go && !r_go_d) ? 4'd0 : r_wcnt;

    always_comb begin
        w_vslot = 1'b0;
        case (bw)
            2'b00:   w_vslot = (w_slot[2:0] == 3'd0);
            2'b01:   w_vslot = (w_slot[1:0] == 2'd0);
            2'b10:   w_vslot = (w_slot[0] == 1'b0);
            default: w_vslot = 1'b1;
        endcase
    end

    always_comb begin
        w_grant = c_OWN_IDLE;
        if (go && w_vslot)
            w_grant = c_OWN_VIDEO;
        else if (r_ref_pend != 2'd0)
            w_grant = c_OWN_REFRESH;
        else if (cpu_req)
            w_grant = c_OWN_CPU;
    end

    assign video_next = cend && rst_n && (w_grant == c_OWN_VIDEO);
    assign cpu_next   = cend && rst_n && (w_grant == c_OWN_CPU);

    assign w_wrap    = cend && (r_refcnt == c_REF_LAST);
    assign w_ref_gnt = cend && (w_grant == c_OWN_REFRESH);

    assign video_strobe = dram_rdstb && (r_owner == c_OWN_VIDEO);
    assign cpu_strobe   = dram_rdstb && (r_owner == c_OWN_CPU) && dram_rnw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner      <= c_OWN_IDLE;
            r_wcnt       <= 4'd0;
            r_go_d       <= 1'b0;
            r_refcnt     <= '0;
            r_ref_pend   <= 2'd0;
            ref_overrun  <= 1'b0;
            dram_req     <= 1'b0;
            dram_rnw     <= 1'b0;
            dram_refresh <= 1'b0;
            dram_addr    <= 21'd0;
            dram_wrdata  <= 16'd0;
            dram_bsel    <= 2'b00;
        end else if (cend) begin
            r_owner      <= w_grant;
            r_wcnt       <= w_slot + 4'd1;
            r_go_d       <= go;
            r_refcnt     <= w_wrap ? '0 : r_refcnt + 1'b1;
            dram_req     <= (w_grant == c_OWN_VIDEO) || (w_grant == c_OWN_CPU);
            dram_refresh <= (w_grant == c_OWN_REFRESH);
            dram_bsel    <= 2'b11;

            if (w_grant == c_OWN_VIDEO) begin
                dram_rnw  <= 1'b1;
                dram_addr <= video_addr;
            end else if (w_grant == c_OWN_CPU) begin
                dram_rnw    <= cpu_rnw;
                dram_addr   <= cpu_addr;
                dram_wrdata <= cpu_wrdata;
                if (!cpu_rnw)
                    dram_bsel <= cpu_wrbsel;
            end

            // A wrap and a refresh grant on the same cend cancel out.
            if (w_wrap && !w_ref_gnt) begin
                if (r_ref_pend == 2'd3)
                    ref_overrun <= 1'b1;
                else
                    r_ref_pend <= r_ref_pend + 2'd1;
            end else if (!w_wrap && w_ref_gnt) begin
                r_ref_pend <= r_ref_pend - 2'd1;
            end
        end
    end

endmodule

`default_nettype wire
